key_debounce_multi: RTL and testbench

- Multi-channel, parametrised push-button conditioner; successor to the single-key 10 ms debouncer.
- Per channel: metastability synchroniser, debounce counter, stable level output, press/release strobes, long-press detection and optional auto-repeat.
- Sits between raw board keys and control logic (menus, mode select). All outputs are in the sys_clk domain.

---
 rtl/key_debounce_pkg.sv | 20 ++
 rtl/key_debounce_ch.sv | 148 ++++++++++++++
 rtl/key_debounce_multi.sv | 66 ++++++
 tb/tb_key_debounce_multi.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel key debouncer.
// Time values in milliseconds are converted to sys_clk cycle counts here.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } hold_state_t;

   function automatic int ms_to_cycles(input int freq_hz, input int ms);
      return freq_hz / 1000 * ms;
   endfunction

   // A counter that must hold max_val needs at least one bit, even when max_val is 0.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce counter, level/edge strobes and the
// long-press / auto-repeat hold FSM driven by the shared ms_tick.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int   CLK_FREQ_HZ = 100_000_000,
   parameter int   DEBOUNCE_MS = 10,
   parameter int   LONG_MS     = 1000,
   parameter int   REPEAT_MS   = 200,
   parameter logic IDLE_LEVEL  = 1'b1,
   parameter int   SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   input  logic ms_tick,
   output logic key_value,
   output logic key_flag,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press,
   output logic repeat_pulse
);

   localparam int   DB_CNT       = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
   localparam int   DB_W         = cnt_width(DB_CNT);
   localparam int   HOLD_MAX     = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int   HOLD_W       = cnt_width(HOLD_MAX);
   localparam logic ACTIVE_LEVEL = ~IDLE_LEVEL;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   key_value_q, key_value_d;
   logic                   key_flag_q, key_flag_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q, long_d;
   logic                   repeat_q, repeat_d;
   hold_state_t            state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                   s;
   logic                   accept;

   assign s = sync_q[SYNC_STAGES-1];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], key_in};
      prev_d   = s;
      db_cnt_d = db_cnt_q;
      accept   = 1'b0;
      if (s != prev_q) begin
         db_cnt_d = DB_W'(DB_CNT);
      end else if (db_cnt_q != '0) begin
         db_cnt_d = db_cnt_q - DB_W'(1);
         // A glitch that settled back to the current level expires silently.
         accept   = (db_cnt_q == DB_W'(1)) && (s != key_value_q);
      end
      key_value_d = accept ? s : key_value_q;
      key_flag_d  = accept;
      press_d     = accept && (s == ACTIVE_LEVEL);
      release_d   = accept && (s == IDLE_LEVEL);
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      if (LONG_MS != 0) begin
         unique case (state_q)
            ST_IDLE: begin
               if (press_d) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = '0;
               end
            end
            ST_HOLD: begin
               if (ms_tick) begin
                  if (hold_cnt_q == HOLD_W'(LONG_MS - 1)) begin
                     long_d     = 1'b1;
                     state_d    = ST_REPEAT;
                     hold_cnt_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                  end
               end
            end
            ST_REPEAT: begin
               if (ms_tick && (REPEAT_MS != 0)) begin
                  if (hold_cnt_q == HOLD_W'(REPEAT_MS - 1)) begin
                     repeat_d   = 1'b1;
                     hold_cnt_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         // Release wins over a coinciding long/repeat expiry.
         if (release_d) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            long_d     = 1'b0;
            repeat_d   = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q      <= {SYNC_STAGES{IDLE_LEVEL}};
         prev_q      <= IDLE_LEVEL;
         db_cnt_q    <= '0;
         key_value_q <= IDLE_LEVEL;
         key_flag_q  <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;
         state_q     <= ST_IDLE;
         hold_cnt_q  <= '0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         db_cnt_q    <= db_cnt_d;
         key_value_q <= key_value_d;
         key_flag_q  <= key_flag_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
         repeat_q    <= repeat_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign key_value     = key_value_q;
   assign key_flag      = key_flag_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: one shared millisecond prescaler broadcast to
// N_CH independent debounce/hold channels.
module key_debounce_multi
   import key_debounce_pkg::*;
#(
   parameter int   N_CH        = 4,
   parameter int   CLK_FREQ_HZ = 100_000_000,
   parameter int   DEBOUNCE_MS = 10,
   parameter int   LONG_MS     = 1000,
   parameter int   REPEAT_MS   = 200,
   parameter logic IDLE_LEVEL  = 1'b1,
   parameter int   SYNC_STAGES = 2
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic [N_CH-1:0] key,
   output logic [N_CH-1:0] key_value,
   output logic [N_CH-1:0] key_flag,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_press,
   output logic [N_CH-1:0] repeat_pulse
);

   localparam int MS_CNT = ms_to_cycles(CLK_FREQ_HZ, 1);
   localparam int PRE_W  = cnt_width(MS_CNT - 1);

   logic [PRE_W-1:0] presc_q, presc_d;
   logic             ms_tick;

   always_comb begin
      ms_tick = (presc_q == PRE_W'(MS_CNT - 1));
      presc_d = ms_tick ? '0 : presc_q + PRE_W'(1);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      key_debounce_ch #(
         .CLK_FREQ_HZ (CLK_FREQ_HZ),
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .LONG_MS     (LONG_MS),
         .REPEAT_MS   (REPEAT_MS),
         .IDLE_LEVEL  (IDLE_LEVEL),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .sys_clk       (sys_clk),
         .sys_rst_n     (sys_rst_n),
         .key_in        (key[i]),
         .ms_tick       (ms_tick),
         .key_value     (key_value[i]),
         .key_flag      (key_flag[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_press    (long_press[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random key activity,
// every cycle compared against a window-based behavioural model.
module tb_key_debounce_multi;

   localparam int   N_CH = 4;
   localparam int   DB   = 10;   // debounce cycles
   localparam int   MS   = 10;   // cycles per ms tick
   localparam int   LONG = 5;    // ms
   localparam int   REP  = 2;    // ms
   localparam int   SYNC = 2;
   localparam logic IDLE = 1'b1;
   localparam int   HL   = SYNC + DB + 2;

   localparam int W_FLAG = 0, W_PRESS = 1, W_REL = 2, W_LONG = 3, W_REP = 4;

   logic            sys_clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic [N_CH-1:0] key = '1;
   logic [N_CH-1:0] key_value, key_flag, press_pulse, release_pulse, long_press, repeat_pulse;

   key_debounce_multi #(
      .N_CH        (N_CH),
      .CLK_FREQ_HZ (10_000),
      .DEBOUNCE_MS (1),
      .LONG_MS     (LONG),
      .REPEAT_MS   (REP),
      .IDLE_LEVEL  (IDLE),
      .SYNC_STAGES (SYNC)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .key           (key),
      .key_value     (key_value),
      .key_flag      (key_flag),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .repeat_pulse  (repeat_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: a key level is accepted once the synchronised sample
   // has held one value for DB+1 consecutive samples right after a change.
   logic            hist [N_CH][HL];
   logic [N_CH-1:0] m_kv, e_flag, e_press, e_rel, e_long, e_rep;
   bit              held [N_CH];
   int              ticks [N_CH];
   int              press_edge [N_CH];
   int              n_edge;

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         for (int j = 0; j < HL; j++) hist[c][j] = IDLE;
         held[c]  = 1'b0;
         ticks[c] = 0;
      end
      m_kv    = {N_CH{IDLE}};
      e_flag  = '0;
      e_press = '0;
      e_rel   = '0;
      e_long  = '0;
      e_rep   = '0;
      n_edge  = 0;
   endtask

   task automatic model_step();
      bit   tick, stable;
      logic v;
      n_edge++;
      tick    = (n_edge % MS) == 0;
      e_flag  = '0;
      e_press = '0;
      e_rel   = '0;
      e_long  = '0;
      e_rep   = '0;
      for (int c = 0; c < N_CH; c++) begin
         for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
         hist[c][0] = key[c];
         v      = hist[c][SYNC];
         stable = 1'b1;
         for (int j = SYNC; j <= SYNC + DB; j++) if (hist[c][j] !== v) stable = 1'b0;
         if (stable && hist[c][SYNC+DB+1] !== v && v !== m_kv[c]) begin
            m_kv[c]   = v;
            e_flag[c] = 1'b1;
            if (v == IDLE) e_rel[c] = 1'b1;
            else e_press[c] = 1'b1;
         end
         if (e_rel[c]) begin
            held[c] = 1'b0;
         end else if (held[c] && tick) begin
            ticks[c]++;
            if (ticks[c] == LONG) e_long[c] = 1'b1;
            else if (ticks[c] > LONG && ((ticks[c] - LONG) % REP) == 0) e_rep[c] = 1'b1;
         end
         if (e_press[c]) begin
            held[c]       = 1'b1;
            ticks[c]      = 0;
            press_edge[c] = n_edge;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge sys_clk);
         if (!sys_rst_n) model_reset();
         else model_step();
         #1;
         check("m_key_value", key_value, m_kv);
         check("m_key_flag", key_flag, e_flag);
         check("m_press", press_pulse, e_press);
         check("m_release", release_pulse, e_rel);
         check("m_long", long_press, e_long);
         check("m_repeat", repeat_pulse, e_rep);
      end
   end

   function automatic logic [N_CH-1:0] sel_out(input int which);
      logic [N_CH-1:0] v;
      case (which)
         W_FLAG:  v = key_flag;
         W_PRESS: v = press_pulse;
         W_REL:   v = release_pulse;
         W_LONG:  v = long_press;
         default: v = repeat_pulse;
      endcase
      return v;
   endfunction

   // Edges until the selected strobe bit rises; -1 if it never does within limit.
   task automatic wait_bit(input int which, input int ch, input int limit, output int cyc);
      logic [N_CH-1:0] v;
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge sys_clk);
         #1;
         v = sel_out(which);
         if (v[ch]) begin
            cyc = i;
            break;
         end
      end
   endtask

   initial begin
      int              cyc, c_long, elapsed, p_edge, l_edge;
      int              remain [N_CH];
      logic [N_CH-1:0] acc;

      key       = '1;
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("rst_key_value", key_value, 4'b1111);
      check("rst_strobes", {key_flag, press_pulse, release_pulse, long_press, repeat_pulse}, '0);
      sys_rst_n = 1'b1;
      repeat (20) @(negedge sys_clk);

      // Clean press on channel 0
      key[0] = 1'b0;
      repeat (12) @(posedge sys_clk);
      #1;
      check("t1_press_early", press_pulse, 4'b0000);
      @(posedge sys_clk);
      #1;
      check("t1_press", press_pulse, 4'b0001);
      check("t1_flag", key_flag, 4'b0001);
      check("t1_value", key_value, 4'b1110);
      @(posedge sys_clk);
      #1;
      check("t1_press_width", press_pulse, 4'b0000);
      @(negedge sys_clk);
      key[0] = 1'b1;
      repeat (20) @(negedge sys_clk);

      // Short glitch on channel 1 must be swallowed
      key[1] = 1'b0;
      repeat (6) @(negedge sys_clk);
      key[1] = 1'b1;
      wait_bit(W_FLAG, 1, 25, cyc);
      check("t2_glitch_flag", cyc, -1);
      check("t2_glitch_value", key_value[1], 1'b1);

      // Bouncing press on channel 1
      @(negedge sys_clk);
      for (int i = 0; i < 10; i++) begin
         key[1] = ~key[1];
         repeat (3) @(negedge sys_clk);
      end
      key[1] = 1'b0;
      wait_bit(W_PRESS, 1, 20, cyc);
      check("t2_bounce_press_latency", cyc, 13);
      wait_bit(W_PRESS, 1, 20, cyc);
      check("t2_bounce_single_press", cyc, -1);
      @(negedge sys_clk);
      key[1] = 1'b1;
      repeat (20) @(negedge sys_clk);

      // Long press and auto-repeat on channel 2
      key[2] = 1'b0;
      wait_bit(W_PRESS, 2, 20, cyc);
      check("t3_press", cyc, 13);
      wait_bit(W_LONG, 2, 70, c_long);
      check("t3_long_window", (c_long >= 40 && c_long <= 60), 1);
      wait_bit(W_REP, 2, 30, cyc);
      check("t3_repeat1", cyc, 20);
      wait_bit(W_REP, 2, 30, cyc);
      check("t3_repeat2", cyc, 20);
      elapsed = 13 + c_long + 40;
      @(negedge sys_clk);
      if (elapsed < 150) repeat (150 - elapsed) @(negedge sys_clk);
      key[2] = 1'b1;
      wait_bit(W_REL, 2, 20, cyc);
      check("t3_release", cyc, 13);
      wait_bit(W_REP, 2, 40, cyc);
      check("t3_no_repeat_after_release", cyc, -1);
      @(negedge sys_clk);

      // Release lands exactly on the long-press tick of channel 3
      key[3] = 1'b0;
      wait_bit(W_PRESS, 3, 20, cyc);
      check("t4_press", cyc, 13);
      p_edge = press_edge[3];
      l_edge = ((p_edge / MS) + 1) * MS + (LONG - 1) * MS;
      for (int g = 0; g < 300 && n_edge < l_edge - 13; g++) @(negedge sys_clk);
      key[3] = 1'b1;
      repeat (13) @(posedge sys_clk);
      #1;
      check("t4_release", release_pulse[3], 1'b1);
      check("t4_long_suppressed", long_press[3], 1'b0);
      wait_bit(W_LONG, 3, 60, cyc);
      check("t4_no_late_long", cyc, -1);

      // All channels pressed together
      repeat (5) @(negedge sys_clk);
      key = '0;
      repeat (13) @(posedge sys_clk);
      #1;
      check("t5_press_all", press_pulse, 4'b1111);
      check("t5_flag_all", key_flag, 4'b1111);
      @(posedge sys_clk);
      #1;
      check("t5_press_width", press_pulse, 4'b0000);

      // Reset while channels are repeating
      wait_bit(W_LONG, 0, 70, cyc);
      check("t6_long_seen", (cyc >= 35 && cyc <= 60), 1);
      repeat (5) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      check("t6_rst_value", key_value, 4'b1111);
      check("t6_rst_strobes", {key_flag, press_pulse, release_pulse, long_press, repeat_pulse}, '0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge sys_clk);
         #1;
         check("t6_quiet", {press_pulse, release_pulse}, '0);
      end
      @(posedge sys_clk);
      #1;
      check("t6_repress", press_pulse, 4'b1111);
      check("t6_no_release", release_pulse, 4'b0000);
      acc = '0;
      for (int i = 0; i < 30; i++) begin
         @(posedge sys_clk);
         #1;
         acc |= release_pulse;
      end
      check("t6_no_spurious_release", acc, 4'b0000);

      // Random key activity with one reset pulse in the middle
      @(negedge sys_clk);
      key = '1;
      repeat (20) @(negedge sys_clk);
      for (int c = 0; c < N_CH; c++) remain[c] = $urandom_range(1, 40);
      for (int i = 0; i < 1500; i++) begin
         @(negedge sys_clk);
         if (i == 700) sys_rst_n = 1'b0;
         else if (i == 702) sys_rst_n = 1'b1;
         for (int c = 0; c < N_CH; c++) begin
            if (remain[c] == 0) begin
               key[c]    = ~key[c];
               remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(10, 90);
            end else begin
               remain[c]--;
            end
         end
      end

      @(negedge sys_clk);
      key = '1;
      repeat (20) @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
